// File: rtl/wb_single_initiator.sv
// Wishbone classic (B3) single-transaction initiator: takes one command on a
// valid/ready port, runs one read or write bus cycle, returns data or timeout.
module wb_single_initiator #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 8
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic        cmd_we_i,
  input  logic [31:0] cmd_adr_i,
  input  logic [31:0] cmd_dat_i,
  input  logic [3:0]  cmd_sel_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_dat_o,
  output logic        rsp_err_o,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic        wbm_ack_i,
  input  logic [31:0] wbm_dat_i
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUS,
    S_RESP
  } state_t;

  // Last counter value before giving up; unused when TIMEOUT is 0.
  localparam int unsigned TO_LAST = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             accept;
  logic             timeout_hit;

  logic        cmd_ready_nx;
  logic        rsp_valid_nx;
  logic [31:0] rsp_dat_nx;
  logic        rsp_err_nx;
  logic        cyc_nx;
  logic        we_nx;
  logic [3:0]  sel_nx;
  logic [31:0] adr_nx;
  logic [31:0] dat_nx;

  assign accept      = (state == S_IDLE) && cmd_valid_i && cmd_ready_o;
  assign timeout_hit = (TIMEOUT != 0) && (cnt == CNT_W'(TO_LAST));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    // NOTE: default first so no path through the case leaves state_nx
    // unassigned, which would infer a latch.
    state_nx = state;
    unique case (state)
      S_IDLE:  if (accept)                     state_nx = S_BUS;
      S_BUS:   if (wbm_ack_i || timeout_hit)   state_nx = S_RESP;
      S_RESP:  if (rsp_ready_i)                state_nx = S_IDLE;
      default:                                 state_nx = S_IDLE;
    endcase
  end

  // Next values of the registered outputs, derived from the transition taken.
  always_comb begin
    cmd_ready_nx = (state_nx == S_IDLE);
    rsp_valid_nx = (state_nx == S_RESP);
    cyc_nx       = (state_nx == S_BUS);
    cnt_nx       = (state == S_BUS && state_nx == S_BUS) ? cnt + 1'b1 : '0;

    we_nx  = wbm_we_o;
    sel_nx = wbm_sel_o;
    adr_nx = wbm_adr_o;
    dat_nx = wbm_dat_o;
    if (state_nx != S_BUS) begin
      we_nx  = 1'b0;
      sel_nx = '0;
      adr_nx = '0;
      dat_nx = '0;
    end else if (state == S_IDLE) begin
      we_nx  = cmd_we_i;
      sel_nx = cmd_sel_i;
      adr_nx = cmd_adr_i;
      dat_nx = cmd_dat_i;
    end

    rsp_dat_nx = rsp_dat_o;
    rsp_err_nx = rsp_err_o;
    if (state == S_BUS && state_nx == S_RESP) begin
      // Ack takes priority over a timeout landing on the same cycle.
      if (wbm_ack_i) begin
        rsp_dat_nx = wbm_we_o ? 32'h0 : wbm_dat_i;
        rsp_err_nx = 1'b0;
      end else begin
        rsp_dat_nx = 32'h0;
        rsp_err_nx = 1'b1;
      end
    end else if (state == S_RESP && state_nx == S_IDLE) begin
      rsp_dat_nx = 32'h0;
      rsp_err_nx = 1'b0;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      cnt         <= '0;
      cmd_ready_o <= 1'b0;
      rsp_valid_o <= 1'b0;
      rsp_dat_o   <= '0;
      rsp_err_o   <= 1'b0;
      wbm_cyc_o   <= 1'b0;
      wbm_stb_o   <= 1'b0;
      wbm_we_o    <= 1'b0;
      wbm_sel_o   <= '0;
      wbm_adr_o   <= '0;
      wbm_dat_o   <= '0;
    end else begin
      cnt         <= cnt_nx;
      cmd_ready_o <= cmd_ready_nx;
      rsp_valid_o <= rsp_valid_nx;
      rsp_dat_o   <= rsp_dat_nx;
      rsp_err_o   <= rsp_err_nx;
      wbm_cyc_o   <= cyc_nx;
      wbm_stb_o   <= cyc_nx;
      wbm_we_o    <= we_nx;
      wbm_sel_o   <= sel_nx;
      wbm_adr_o   <= adr_nx;
      wbm_dat_o   <= dat_nx;
    end
  end

endmodule

// File: tb/tb_wb_single_initiator.sv
// Self-checking bench for wb_single_initiator: directed transactions against a
// transaction-level model, plus literal expectations for each scenario.
module tb_wb_single_initiator;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        wb_rst_i = 1'b1;
  logic        cmd_valid_i = 1'b0;
  logic        cmd_ready_o;
  logic        cmd_we_i = 1'b0;
  logic [31:0] cmd_adr_i = '0;
  logic [31:0] cmd_dat_i = '0;
  logic [3:0]  cmd_sel_i = '0;
  logic        rsp_valid_o;
  logic        rsp_ready_i = 1'b0;
  logic [31:0] rsp_dat_o;
  logic        rsp_err_o;
  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic        wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o;
  logic [31:0] wbm_dat_o;
  logic        wbm_ack_i = 1'b0;
  logic [31:0] wbm_dat_i = '0;

  always #5 clk = ~clk;

  wb_single_initiator #(.TIMEOUT(TO), .CNT_W(4)) dut (
    .wb_clk_i    (clk),
    .wb_rst_i    (wb_rst_i),
    .cmd_valid_i (cmd_valid_i),
    .cmd_ready_o (cmd_ready_o),
    .cmd_we_i    (cmd_we_i),
    .cmd_adr_i   (cmd_adr_i),
    .cmd_dat_i   (cmd_dat_i),
    .cmd_sel_i   (cmd_sel_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_ready_i (rsp_ready_i),
    .rsp_dat_o   (rsp_dat_o),
    .rsp_err_o   (rsp_err_o),
    .wbm_cyc_o   (wbm_cyc_o),
    .wbm_stb_o   (wbm_stb_o),
    .wbm_we_o    (wbm_we_o),
    .wbm_sel_o   (wbm_sel_o),
    .wbm_adr_o   (wbm_adr_o),
    .wbm_dat_o   (wbm_dat_o),
    .wbm_ack_i   (wbm_ack_i),
    .wbm_dat_i   (wbm_dat_i)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model of the command in flight and of how the slave will answer it.
  logic        m_we  = 1'b0;
  logic [31:0] m_adr = '0;
  logic [31:0] m_dat = '0;
  logic [31:0] m_rd  = '0;
  logic [3:0]  m_sel = '0;
  int          m_ack_at = 0;      // stb cycle on which the slave acks; 0 = never
  logic        stray_ack = 1'b0;

  function automatic bit model_acked();
    return (m_ack_at > 0) && (m_ack_at <= TO);
  endfunction

  function automatic logic [32:0] model_rsp();
    if (model_acked()) return {(m_we ? 32'h0 : m_rd), 1'b0};
    return {32'h0, 1'b1};
  endfunction

  function automatic int model_stb();
    return model_acked() ? m_ack_at : TO;
  endfunction

  // Slave: acks on the m_ack_at-th strobe cycle, junk data otherwise.
  int s_cnt = 0;
  always @(negedge clk) begin
    if (wbm_stb_o) s_cnt++;
    else           s_cnt = 0;
    wbm_ack_i = stray_ack || (wbm_stb_o && m_ack_at != 0 && s_cnt == m_ack_at);
    wbm_dat_i = wbm_ack_i ? m_rd : $urandom;
  end

  // Compare process: checks DUT outputs against the model every cycle.
  int   seen_stb = 0;
  logic prev_rv  = 1'b0;
  always @(negedge clk) begin
    logic [70:0] bus_vec, exp_vec;
    if (wb_rst_i) begin
      seen_stb = 0;
      prev_rv  = 1'b0;
    end else begin
      bus_vec = {wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o};
      exp_vec = wbm_cyc_o ? {2'b11, m_we, m_sel, m_adr, m_dat} : 71'h0;
      check("bus_outputs", 128'(bus_vec), 128'(exp_vec));
      check("phase_excl",
            128'((int'(cmd_ready_o) + int'(wbm_cyc_o) + int'(rsp_valid_o)) <= 1), 128'(1));
      if (rsp_valid_o) check("rsp_model", 128'({rsp_dat_o, rsp_err_o}), 128'(model_rsp()));
      if (wbm_cyc_o) seen_stb++;
      if (rsp_valid_o && !prev_rv) begin
        check("stb_model", 128'(seen_stb), 128'(model_stb()));
        seen_stb = 0;
      end
      prev_rv = rsp_valid_o;
    end
  end

  task automatic issue(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                       input logic [3:0] sel, input int ack_at, input logic [31:0] rd);
    bit ok = 0;
    m_we = we; m_adr = adr; m_dat = dat; m_sel = sel; m_ack_at = ack_at; m_rd = rd;
    @(posedge clk); #1;
    cmd_valid_i = 1'b1; cmd_we_i = we; cmd_adr_i = adr; cmd_dat_i = dat; cmd_sel_i = sel;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (cmd_ready_o) ok = 1;
    end
    check("cmd_accept_wait", 128'(ok), 128'(1));
    @(posedge clk); #1;
    cmd_valid_i = 1'b0;
    cmd_we_i  = 1'($urandom);
    cmd_adr_i = $urandom;
    cmd_dat_i = $urandom;
    cmd_sel_i = 4'($urandom);
  endtask

  task automatic finish_txn(input int delay, input logic [31:0] exp_dat,
                            input logic exp_err, input int exp_stb);
    bit          got = 0;
    int          stb = 0;
    logic [32:0] cap;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (rsp_valid_o) got = 1;
      else if (wbm_cyc_o) stb++;
    end
    check("rsp_valid_wait", 128'(got), 128'(1));
    check("rsp_dat", 128'(rsp_dat_o), 128'(exp_dat));
    check("rsp_err", 128'(rsp_err_o), 128'(exp_err));
    check("stb_count", 128'(stb), 128'(exp_stb));
    cap = {rsp_dat_o, rsp_err_o};
    for (int i = 0; i < delay; i++) begin
      @(negedge clk);
      check("backpressure_hold", 128'({rsp_valid_o, cmd_ready_o, wbm_cyc_o, rsp_dat_o, rsp_err_o}),
            128'({3'b100, cap}));
    end
    @(posedge clk); #1;
    rsp_ready_i = 1'b1;
    @(posedge clk); #1;
    rsp_ready_i = 1'b0;
    @(negedge clk);
    check("post_handshake", 128'({rsp_valid_o, cmd_ready_o, wbm_cyc_o}), 128'(3'b010));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_outputs",
          128'({cmd_ready_o, rsp_valid_o, rsp_dat_o, rsp_err_o, wbm_cyc_o, wbm_stb_o,
                wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o}), 128'(0));
    @(posedge clk); #1;
    wb_rst_i = 1'b0;

    // Write, slave acks on the 3rd strobe cycle.
    issue(1'b1, 32'h3000_0004, 32'hDEAD_BEEF, 4'hF, 3, 32'h1111_2222);
    finish_txn(0, 32'h0, 1'b0, 3);

    // Read with zero-wait-state ack.
    issue(1'b0, 32'h3000_0000, 32'h0, 4'hF, 1, 32'h1234_5678);
    finish_txn(0, 32'h1234_5678, 1'b0, 1);

    // Read that is never acked: times out after TO strobe cycles.
    issue(1'b0, 32'h3000_0010, 32'h0, 4'h3, 0, 32'h5555_AAAA);
    finish_txn(0, 32'h0, 1'b1, 8);

    // Next command after a timeout is accepted normally.
    issue(1'b1, 32'h3000_0008, 32'h0BAD_F00D, 4'h5, 2, 32'h7777_7777);
    finish_txn(0, 32'h0, 1'b0, 2);

    // Ack on the last permitted cycle wins over the timeout.
    issue(1'b0, 32'h3000_000C, 32'h0, 4'hF, 8, 32'hA5A5_A5A5);
    finish_txn(0, 32'hA5A5_A5A5, 1'b0, 8);

    // Response backpressure for 5 cycles.
    issue(1'b0, 32'h3000_0018, 32'h0, 4'hC, 2, 32'hCAFE_F00D);
    finish_txn(5, 32'hCAFE_F00D, 1'b0, 2);

    // Stray ack while idle is ignored.
    @(posedge clk); #1;
    stray_ack = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("idle_stray_ack", 128'({rsp_valid_o, wbm_cyc_o, cmd_ready_o}), 128'(3'b001));
    end
    @(posedge clk); #1;
    stray_ack = 1'b0;

    // Reset in the middle of a bus cycle, then a late ack.
    issue(1'b0, 32'h3000_0020, 32'h0, 4'hF, 0, 32'h0F0F_0F0F);
    repeat (2) @(negedge clk);
    check("bus_before_reset", 128'(wbm_cyc_o), 128'(1));
    @(posedge clk); #1;
    wb_rst_i = 1'b1;
    @(posedge clk); #1;
    wb_rst_i  = 1'b0;
    stray_ack = 1'b1;
    @(negedge clk);
    check("mid_reset_outputs",
          128'({cmd_ready_o, rsp_valid_o, rsp_dat_o, rsp_err_o, wbm_cyc_o, wbm_stb_o,
                wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o}), 128'(0));
    @(posedge clk); #1;
    stray_ack = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("no_rsp_after_reset", 128'({rsp_valid_o, wbm_cyc_o}), 128'(2'b00));
    end

    // Fresh command completes after the abandoned one.
    issue(1'b0, 32'h3000_0024, 32'h0, 4'h9, 1, 32'h0F0F_1234);
    finish_txn(0, 32'h0F0F_1234, 1'b0, 1);

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
